// File: rtl/adc_sample_recorder.sv
// rtl/adc_sample_recorder.sv - threshold-armed one-shot ADC sample recorder with PCM playback
module adc_sample_recorder #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 12,
  parameter logic [DATA_W-1:0] THRESH = 24'h080000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              advance,
  input  logic [DATA_W-1:0] adc_in,
  input  logic              rec_req,
  input  logic              play_req,
  output logic [DATA_W-1:0] pcm_out,
  output logic [ADDR_W:0]   rec_len,
  output logic              armed,
  output logic              recording,
  output logic              playing
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RECORD,
    S_PLAY
  } state_t;

  state_t             state, state_nx;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_nx;
  logic [PTR_W-1:0]   rd_ptr, rd_ptr_nx;
  logic [PTR_W-1:0]   rd_base;
  logic [PTR_W-1:0]   rec_len_nx;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_valid;
  logic [DATA_W-1:0]  ram_q;
  logic [DATA_W-1:0]  adc_abs;
  logic               over_thresh;

  logic [DATA_W-1:0]  mem [DEPTH];

  // Magnitude with the most-negative code clamped so it still trips the threshold
  always_comb begin
    adc_abs = adc_in;
    if (adc_in[DATA_W-1]) begin
      if (adc_in == MOST_NEG) adc_abs = MOST_POS;
      else                    adc_abs = -adc_in;
    end
  end

  assign over_thresh = (adc_abs >= THRESH);

  always_comb begin
    state_nx   = state;
    wr_ptr_nx  = wr_ptr;
    rd_ptr_nx  = rd_ptr;
    rec_len_nx = rec_len;
    wr_en      = 1'b0;
    wr_addr    = wr_ptr[ADDR_W-1:0];
    rd_en      = 1'b0;
    rd_base    = rd_ptr;
    rd_addr    = rd_ptr[ADDR_W-1:0];

    case (state)
      S_IDLE: begin
        if (rec_req) begin
          state_nx = S_ARMED;
        end else if (play_req && (rec_len != '0)) begin
          state_nx  = S_PLAY;
          rd_ptr_nx = '0;
        end
      end

      S_ARMED: begin
        if (rec_req) begin
          state_nx = S_IDLE;
        end else if (advance && over_thresh) begin
          state_nx  = S_RECORD;
          wr_en     = 1'b1;
          wr_addr   = '0;
          wr_ptr_nx = PTR_W'(1);
        end
      end

      S_RECORD: begin
        // A sample arriving with the stop request is still kept and counted
        if (advance) begin
          wr_en     = 1'b1;
          wr_ptr_nx = wr_ptr + PTR_W'(1);
          if (rec_req || (wr_ptr == LAST_ADDR)) begin
            state_nx   = S_IDLE;
            rec_len_nx = wr_ptr + PTR_W'(1);
          end
        end else if (rec_req) begin
          state_nx   = S_IDLE;
          rec_len_nx = wr_ptr;
        end
      end

      S_PLAY: begin
        if (rec_req) begin
          state_nx = S_ARMED;
        end else begin
          rd_base   = play_req ? '0 : rd_ptr;
          rd_addr   = rd_base[ADDR_W-1:0];
          rd_ptr_nx = rd_base;
          if (advance) begin
            if (rd_base < rec_len) begin
              rd_en     = 1'b1;
              rd_ptr_nx = rd_base + PTR_W'(1);
            end else begin
              state_nx = S_IDLE;
            end
          end
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rec_len   <= '0;
      rd_valid  <= 1'b0;
      pcm_out   <= '0;
      armed     <= 1'b0;
      recording <= 1'b0;
      playing   <= 1'b0;
    end else begin
      state     <= state_nx;
      wr_ptr    <= wr_ptr_nx;
      rd_ptr    <= rd_ptr_nx;
      rec_len   <= rec_len_nx;
      rd_valid  <= rd_en;
      armed     <= (state_nx == S_ARMED);
      recording <= (state_nx == S_RECORD);
      playing   <= (state_nx == S_PLAY);
      // An in-flight read is dropped if playback ends before its data lands
      if (state_nx != S_PLAY) pcm_out <= '0;
      else if (rd_valid)      pcm_out <= ram_q;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= adc_in;
    if (rd_en) ram_q <= mem[rd_addr];
  end

endmodule

// File: tb/tb_adc_sample_recorder.sv
// tb/tb_adc_sample_recorder.sv - bench for adc_sample_recorder
module tb_adc_sample_recorder;

  localparam int DEPTH  = 4096;
  localparam int THRESH = 32'h080000;
  localparam int SATMAX = 32'h7FFFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        advance = 1'b0;
  logic [23:0] adc_in = '0;
  logic        rec_req = 1'b0;
  logic        play_req = 1'b0;
  logic [23:0] pcm_out;
  logic [12:0] rec_len;
  logic        armed, recording, playing;

  int errors = 0;
  int checks = 0;
  logic [23:0] stream[$];
  logic [23:0] take[$];
  logic [23:0] p;
  int          prev_len;

  adc_sample_recorder dut (
    .clock    (clock),
    .reset    (reset),
    .advance  (advance),
    .adc_in   (adc_in),
    .rec_req  (rec_req),
    .play_req (play_req),
    .pcm_out  (pcm_out),
    .rec_len  (rec_len),
    .armed    (armed),
    .recording(recording),
    .playing  (playing)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_abs(input logic [23:0] x);
    int v;
    v = int'($signed(x));
    if (v < 0) v = -v;
    if (v > SATMAX) v = SATMAX;
    return v;
  endfunction

  // Expected take: stream from first loud sample onward, capped at the RAM depth
  function automatic void build_take();
    bit found;
    found = 1'b0;
    take.delete();
    foreach (stream[i]) begin
      if (!found && ref_abs(stream[i]) >= THRESH) found = 1'b1;
      if (found && take.size() < DEPTH) take.push_back(stream[i]);
    end
  endfunction

  task automatic step(input logic adv, input logic [23:0] data, input logic rr, input logic pr);
    @(negedge clock);
    advance  = adv;
    adc_in   = data;
    rec_req  = rr;
    play_req = pr;
    @(posedge clock);
    #1;
    advance  = 1'b0;
    rec_req  = 1'b0;
    play_req = 1'b0;
  endtask

  task automatic frame(input logic [23:0] data, input logic rr, input logic pr,
                       output logic [23:0] pcm2);
    step(1'b1, data, rr, pr);
    @(posedge clock);
    #1 pcm2 = pcm_out;
    @(posedge clock);
    @(posedge clock);
  endtask

  task automatic play_and_check(input string tag);
    for (int i = 0; i <= take.size(); i++) begin
      frame(24'h0, 1'b0, 1'b0, p);
      check(tag, 32'(p), (i < take.size()) ? 32'(take[i]) : 32'h0);
    end
    check({tag, "_done"}, 32'(playing), 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_pcm", 32'(pcm_out), 0);
    check("rst_len", 32'(rec_len), 0);
    check("rst_armed", 32'(armed), 0);
    check("rst_rec", 32'(recording), 0);
    check("rst_play", 32'(playing), 0);
    @(negedge clock);
    reset = 1'b0;

    // play with empty take is ignored
    step(1'b0, 24'h0, 1'b0, 1'b1);
    check("empty_play", 32'(playing), 0);
    check("empty_pcm", 32'(pcm_out), 0);

    // directed take: three quiet samples skipped
    step(1'b0, 24'h0, 1'b1, 1'b0);
    check("arm", 32'(armed), 1);
    stream = '{24'h000100, 24'h000100, 24'h000100, 24'h0A0000, 24'h000010, 24'h000020};
    for (int i = 0; i < stream.size(); i++) begin
      frame(stream[i], 1'b0, 1'b0, p);
      if (i == 2) check("quiet_armed", 32'(armed), 1);
      if (i == 2) check("quiet_norec", 32'(recording), 0);
      if (i == 3) check("trig_rec", 32'(recording), 1);
    end
    check("len_held", 32'(rec_len), 0);
    step(1'b0, 24'h0, 1'b1, 1'b0);
    build_take();
    check("stop_rec", 32'(recording), 0);
    check("stop_armed", 32'(armed), 0);
    check("len3", 32'(rec_len), 32'(take.size()));
    step(1'b0, 24'h0, 1'b0, 1'b1);
    check("play_on", 32'(playing), 1);
    play_and_check("pb3");

    // random take with threshold boundaries; stop coincides with last sample
    step(1'b0, 24'h0, 1'b1, 1'b0);
    stream.delete();
    stream.push_back(24'h07FFFF);
    stream.push_back(24'hF80001);
    repeat (3) stream.push_back(24'($urandom_range(0, 32'h07FFFF)));
    stream.push_back(24'hF80000);
    repeat (30) stream.push_back(24'($urandom()));
    for (int i = 0; i < stream.size(); i++)
      frame(stream[i], (i == stream.size() - 1), 1'b0, p);
    build_take();
    check("rnd_stop", 32'(recording), 0);
    check("rnd_len", 32'(rec_len), 32'(take.size()));
    step(1'b0, 24'h0, 1'b0, 1'b1);
    play_and_check("pb_rnd");

    // retrigger at sample 2, then rec_req aborts playback
    step(1'b0, 24'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      frame(24'h0, 1'b0, 1'b0, p);
      check("pre_retrig", 32'(p), 32'(take[i]));
    end
    step(1'b0, 24'h0, 1'b0, 1'b1);
    frame(24'h0, 1'b0, 1'b0, p);
    check("retrig0", 32'(p), 32'(take[0]));
    frame(24'h0, 1'b0, 1'b0, p);
    check("retrig1", 32'(p), 32'(take[1]));
    step(1'b0, 24'h0, 1'b1, 1'b0);
    check("abort_pcm", 32'(pcm_out), 0);
    check("abort_armed", 32'(armed), 1);
    check("abort_play", 32'(playing), 0);

    // full-depth take triggered by the saturating most-negative code
    prev_len = take.size();
    stream.delete();
    stream.push_back(24'h800000);
    repeat (DEPTH - 1) stream.push_back(24'($urandom()));
    for (int i = 0; i < stream.size(); i++) begin
      frame(stream[i], 1'b0, 1'b0, p);
      if (i == 2000) check("full_mid_rec", 32'(recording), 1);
      if (i == 2000) check("full_mid_len", 32'(rec_len), 32'(prev_len));
    end
    build_take();
    check("full_stop", 32'(recording), 0);
    check("full_len", 32'(rec_len), 32'(take.size()));
    step(1'b0, 24'h0, 1'b0, 1'b1);
    play_and_check("pb_full");

    // asynchronous reset in the middle of a recording
    step(1'b0, 24'h0, 1'b1, 1'b0);
    frame(24'h7FFFFF, 1'b0, 1'b0, p);
    check("pre_rst_rec", 32'(recording), 1);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("arst_rec", 32'(recording), 0);
    check("arst_len", 32'(rec_len), 0);
    check("arst_pcm", 32'(pcm_out), 0);
    check("arst_armed", 32'(armed), 0);
    @(negedge clock);
    reset = 1'b0;
    step(1'b0, 24'h0, 1'b0, 1'b1);
    check("arst_noplay", 32'(playing), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
